// File: rtl/data_distributor_pkg.sv
// Shared slot map and state encoding for the data distributor and the result selector.
// Both ends import this package so they agree on which slot feeds which output.
package data_distributor_pkg;

  localparam int unsigned DIST_NUM_SLOTS = 9;

  // 64-bit outputs are {hi,lo}; the lower slot index is the high half.
  localparam int unsigned SLOT_D1_HI = 0;
  localparam int unsigned SLOT_D1_LO = 1;
  localparam int unsigned SLOT_D3_HI = 2;
  localparam int unsigned SLOT_D3_LO = 3;
  localparam int unsigned SLOT_D5_HI = 4;
  localparam int unsigned SLOT_D5_LO = 5;
  localparam int unsigned SLOT_D7    = 6;
  localparam int unsigned SLOT_D8    = 7;
  localparam int unsigned SLOT_D9    = 8;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PUBLISH = 2'd1,
    HOLD    = 2'd2
  } dist_state_e;

endpackage

// File: rtl/data_distributor_if.sv
// Word-stream valid/ready handshake into the data distributor.
interface data_distributor_if #(
  parameter int WORD_W = 32
);
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/data_distributor_slot_bank.sv
// dist_slot_bank: NUM_SLOTS x WORD_W shadow registers with indexed write decode.
// slot_view shows the shadows with the current write already merged in.
module dist_slot_bank #(
  parameter int WORD_W    = 32,
  parameter int NUM_SLOTS = 9,
  parameter int CNT_W     = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [CNT_W-1:0]                 wr_idx,
  input  logic [WORD_W-1:0]                wr_data,
  output logic [NUM_SLOTS-1:0][WORD_W-1:0] slot_view
);

  logic [NUM_SLOTS-1:0][WORD_W-1:0] shadow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (wr_en && wr_idx == CNT_W'(i)) shadow[i] <= wr_data;
      end
    end
  end

  // Merged view lets the top publish the final word in the same cycle it arrives.
  always_comb begin
    slot_view = shadow;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (wr_en && wr_idx == CNT_W'(i)) slot_view[i] = wr_data;
    end
  end

endmodule

// File: rtl/data_distributor.sv
// data_distributor: scatters a 32-bit word stream into 9 slots and publishes them atomically per frame.
// Optional DATA_DIST_ACK_EN holds each published frame until the consumer asserts frame_ack.
module data_distributor
  import data_distributor_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int NUM_SLOTS = 9,
  parameter int CNT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_distributor_if.slave     in_bus,
  input  logic                  frame_abort,
  input  logic                  frame_ack,
  output logic [CNT_W-1:0]      slot_idx,
  output logic                  frame_done,
  output logic [2*WORD_W-1:0]   out_data1,
  output logic [2*WORD_W-1:0]   out_data3,
  output logic [2*WORD_W-1:0]   out_data5,
  output logic [WORD_W-1:0]     out_data7,
  output logic [WORD_W-1:0]     out_data8,
  output logic [WORD_W-1:0]     out_data9
);

  if (NUM_SLOTS != DIST_NUM_SLOTS) begin : g_bad_slots
    $error("data_distributor: NUM_SLOTS must be 9");
  end
  if (CNT_W < $clog2(NUM_SLOTS)) begin : g_bad_cnt
    $error("data_distributor: CNT_W too narrow for NUM_SLOTS");
  end

  dist_state_e                      state;
  logic                             in_ready_q;
  logic                             accept;
  logic                             wr_en;
  logic                             last_slot;
  logic [NUM_SLOTS-1:0][WORD_W-1:0] slot_view;

`ifndef DATA_DIST_ACK_EN
  logic unused_frame_ack;
  assign unused_frame_ack = frame_ack;
`endif

  assign in_bus.in_ready = in_ready_q;
  assign accept          = in_bus.in_valid & in_ready_q;
  assign wr_en           = accept & ~frame_abort;
  assign last_slot       = (slot_idx == CNT_W'(NUM_SLOTS - 1));

  dist_slot_bank #(
    .WORD_W   (WORD_W),
    .NUM_SLOTS(NUM_SLOTS),
    .CNT_W    (CNT_W)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_idx   (slot_idx),
    .wr_data  (in_bus.in_data),
    .slot_view(slot_view)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= COLLECT;
      in_ready_q <= 1'b1;
      slot_idx   <= '0;
      frame_done <= 1'b0;
      out_data1  <= '0;
      out_data3  <= '0;
      out_data5  <= '0;
      out_data7  <= '0;
      out_data8  <= '0;
      out_data9  <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (frame_abort) begin
            slot_idx <= '0;
          end else if (accept) begin
            if (last_slot) begin
              slot_idx   <= '0;
              out_data1  <= {slot_view[SLOT_D1_HI], slot_view[SLOT_D1_LO]};
              out_data3  <= {slot_view[SLOT_D3_HI], slot_view[SLOT_D3_LO]};
              out_data5  <= {slot_view[SLOT_D5_HI], slot_view[SLOT_D5_LO]};
              out_data7  <= slot_view[SLOT_D7];
              out_data8  <= slot_view[SLOT_D8];
              out_data9  <= slot_view[SLOT_D9];
              frame_done <= 1'b1;
              in_ready_q <= 1'b0;
              state      <= PUBLISH;
            end else begin
              slot_idx <= slot_idx + 1'b1;
            end
          end
        end
        PUBLISH: begin
`ifdef DATA_DIST_ACK_EN
          if (frame_ack) begin
            in_ready_q <= 1'b1;
            state      <= COLLECT;
          end else begin
            state      <= HOLD;
          end
`else
          in_ready_q <= 1'b1;
          state      <= COLLECT;
`endif
        end
        HOLD: begin
`ifdef DATA_DIST_ACK_EN
          if (frame_ack) begin
            in_ready_q <= 1'b1;
            state      <= COLLECT;
          end
`else
          in_ready_q <= 1'b1;
          state      <= COLLECT;
`endif
        end
        default: begin
          in_ready_q <= 1'b1;
          state      <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_distributor.sv
// Self-checking bench for data_distributor: directed frames plus random traffic against a frame-queue model.
module tb_data_distributor;
  import data_distributor_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_abort;
  logic        frame_ack;
  logic [3:0]  slot_idx;
  logic        frame_done;
  logic [63:0] out_data1, out_data3, out_data5;
  logic [31:0] out_data7, out_data8, out_data9;

  data_distributor_if #(.WORD_W(32)) bus ();

  data_distributor #(
    .WORD_W   (32),
    .NUM_SLOTS(9),
    .CNT_W    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_bus     (bus),
    .frame_abort(frame_abort),
    .frame_ack  (frame_ack),
    .slot_idx   (slot_idx),
    .frame_done (frame_done),
    .out_data1  (out_data1),
    .out_data3  (out_data3),
    .out_data5  (out_data5),
    .out_data7  (out_data7),
    .out_data8  (out_data8),
    .out_data9  (out_data9)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned cyc         = 0;

  // Reference model: words of the frame in progress, last published frame, handshake phase.
  logic [31:0] frame_q[$];
  logic [31:0] pub [9];
  logic        done_exp;
  logic        ready_exp;
  logic        holding;
  int unsigned done_cycles[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [31:0] d,
                            input logic ab, input logic ak);
    logic prev_done;
    prev_done = done_exp;
    if (!r) begin
      frame_q.delete();
      foreach (pub[i]) pub[i] = '0;
      done_exp  = 1'b0;
      ready_exp = 1'b1;
      holding   = 1'b0;
      return;
    end
    done_exp = 1'b0;
    if (prev_done) begin
`ifdef DATA_DIST_ACK_EN
      ready_exp = ak;
      holding   = !ak;
`else
      ready_exp = 1'b1;
`endif
    end else if (holding) begin
      if (ak) begin
        ready_exp = 1'b1;
        holding   = 1'b0;
      end
    end else if (ready_exp) begin
      if (ab) begin
        frame_q.delete();
      end else if (v) begin
        frame_q.push_back(d);
        if (frame_q.size() == 9) begin
          for (int i = 0; i < 9; i++) pub[i] = frame_q[i];
          frame_q.delete();
          done_exp  = 1'b1;
          ready_exp = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("in_ready",   {63'd0, bus.in_ready}, {63'd0, ready_exp});
    chk("frame_done", {63'd0, frame_done},   {63'd0, done_exp});
    chk("slot_idx",   {60'd0, slot_idx},     64'(frame_q.size()));
    chk("out_data1",  out_data1, {pub[0], pub[1]});
    chk("out_data3",  out_data3, {pub[2], pub[3]});
    chk("out_data5",  out_data5, {pub[4], pub[5]});
    chk("out_data7",  {32'd0, out_data7}, {32'd0, pub[6]});
    chk("out_data8",  {32'd0, out_data8}, {32'd0, pub[7]});
    chk("out_data9",  {32'd0, out_data9}, {32'd0, pub[8]});
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check 1 ns later.
  task automatic step(input logic r, input logic v, input logic [31:0] d,
                      input logic ab, input logic ak);
    rst_n        = r;
    bus.in_valid = v;
    bus.in_data  = d;
    frame_abort  = ab;
    frame_ack    = ak;
    @(posedge clk);
    #1;
    model_edge(r, v, d, ab, ak);
    cyc++;
    if (frame_done) done_cycles.push_back(cyc);
    check_all();
  endtask

  task automatic idle(input int n, input logic ak);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, $urandom, 1'b0, ak);
  endtask

  initial begin
    logic [31:0] w;
    int unsigned budget;
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; frame_abort = 1'b0; frame_ack = 1'b0;
    done_exp = 1'b0; ready_exp = 1'b1; holding = 1'b0;
    foreach (pub[i]) pub[i] = '0;

    // Reset state
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("rst_ready", {63'd0, bus.in_ready}, 64'd1);

    // Frame 0x11..0x99 back-to-back
    for (int i = 1; i <= 9; i++) begin
      w = 32'(i * 'h11);
      step(1'b1, 1'b1, w, 1'b0, 1'b0);
    end
    chk("t1_out1", out_data1, 64'h00000011_00000022);
    chk("t1_out5", out_data5, 64'h00000055_00000066);
    chk("t1_out9", {32'd0, out_data9}, 64'h99);
    chk("t1_done", {63'd0, frame_done}, 64'd1);
    chk("t1_ready", {63'd0, bus.in_ready}, 64'd0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    chk("t1_ready2", {63'd0, bus.in_ready}, 64'd1);

    // Same frame with in_valid toggling; slot_idx advances only on accepts
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b0, $urandom, 1'b0, 1'b0);
      w = 32'(i * 'h11);
      step(1'b1, 1'b1, w, 1'b0, 1'b0);
    end
    chk("t2_out1", out_data1, 64'h00000011_00000022);
    idle(2, 1'b1);

    // 4 words, abort with valid high, then full frame 0xA0..0xA8
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0);
    chk("t3_idx", {60'd0, slot_idx}, 64'd0);
    for (int i = 0; i < 9; i++) begin
      w = 32'hA0 + 32'(i);
      step(1'b1, 1'b1, w, 1'b0, 1'b0);
    end
    chk("t3_out1", out_data1, 64'h000000A0_000000A1);
    chk("t3_out9", {32'd0, out_data9}, 64'hA8);
    idle(2, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'b1, ($urandom_range(0, 9) < 7), $urandom,
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));
    end
    idle(2, 1'b1);

    // Reset mid-frame after 5 words
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    step(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
    chk("t4_out1", out_data1, 64'd0);
    chk("t4_idx", {60'd0, slot_idx}, 64'd0);
    chk("t4_done", {63'd0, frame_done}, 64'd0);

    // Held-frame behaviour after publish
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
`ifdef DATA_DIST_ACK_EN
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
      chk("t5_hold_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    chk("t5_ack_ready", {63'd0, bus.in_ready}, 64'd1);
`else
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("t5_ready_2cyc", {63'd0, bus.in_ready}, 64'd1);
`endif

    // Back-to-back frames: 9 accept cycles plus one PUBLISH cycle between pulses
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    done_cycles.delete();
    budget = 0;
    while (done_cycles.size() < 2 && budget < 60) begin
      step(1'b1, 1'b1, $urandom, 1'b0, 1'b1);
      budget++;
    end
    if (done_cycles.size() < 2) begin
      chk("t6_timeout", 64'(done_cycles.size()), 64'd2);
    end else begin
      chk("t6_gap", 64'(done_cycles[1] - done_cycles[0]), 64'd10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
